// File: rtl/spi_slave_port.sv
// SPI slave byte port: synchronizes the bus pins, runs all four SPI modes in the clk
// domain, and presents a one-byte transmit holding register and a one-byte receive register.
module spi_slave_port (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       ncs_i,
  output logic       miso_o,
  output logic       miso_oe,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       busy,
  output logic [2:0] status,
  input  logic       clear_status
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_sck_s1, r_sck_s2, r_sck_d;
  logic       r_mosi_s1, r_mosi_s2, r_mosi_d;
  logic       r_ncs_s1, r_ncs_s2, r_ncs_d;
  logic       r_cpol, r_cpha;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx_sr, r_rx_sr;
  logic [7:0] r_thr;
  logic       r_thr_full;
  logic       r_load_pend;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [2:0] r_status;

  logic w_sck_rise, w_sck_fall, w_ncs_rise, w_ncs_fall;
  logic w_lead, w_trail, w_active;
  logic w_sample, w_shift, w_start, w_stop, w_byte_done;
  logic w_load, w_thr_wr, w_consume;
  logic w_underrun_set, w_overrun_set, w_abort_set;

  // The ncs chain resets low so that ncs already low at reset release is not a falling edge;
  // a rising edge seen while idle is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_mosi_d  <= 1'b0;
      r_ncs_s1  <= 1'b0;
      r_ncs_s2  <= 1'b0;
      r_ncs_d   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop see the pre-edge value of its neighbour,
      // which is what makes this a real shift chain rather than one wire.
      r_sck_s1  <= sck_i;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_mosi_s1 <= mosi_i;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_d  <= r_mosi_s2;
      r_ncs_s1  <= ncs_i;
      r_ncs_s2  <= r_ncs_s1;
      r_ncs_d   <= r_ncs_s2;
    end
  end

  assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
  assign w_ncs_rise  = r_ncs_s2 & ~r_ncs_d;
  assign w_ncs_fall  = ~r_ncs_s2 & r_ncs_d;
  assign w_lead      = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail     = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_active    = (r_state == S_ACTIVE);
  assign w_sample    = w_active & (r_cpha ? w_trail : w_lead);
  assign w_shift     = w_active & (r_cpha ? w_lead : w_trail);
  assign w_start     = (r_state == S_IDLE) & w_ncs_fall;
  assign w_stop      = w_active & w_ncs_rise;
  assign w_byte_done = w_sample & (r_bit_cnt == 3'd7);
  assign w_load      = w_start | (r_load_pend & w_active);
  assign w_thr_wr    = tx_valid & ~r_thr_full;
  assign w_consume   = w_load & r_thr_full;

  assign w_underrun_set = w_load & ~r_thr_full;
  assign w_overrun_set  = w_byte_done & r_rx_valid & ~rx_read;
  assign w_abort_set    = w_stop & (r_bit_cnt != 3'd0);

  always_comb begin
    // NOTE: the default assignment first means every path writes w_state_nxt, so no latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_ncs_fall) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_ncs_rise) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_load_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_pend <= w_byte_done;
      if (w_start) begin
        r_cpol <= cpol;
        r_cpha <= cpha;
      end
      if (w_ncs_fall || w_stop) r_bit_cnt <= 3'd0;
      else if (w_sample)        r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // A shift edge seen with the counter at 0 is the one that would lose bit7 of a freshly
  // loaded byte (cpha=0: trailing edge after the 8th sample; cpha=1: first leading edge).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_sr <= 8'hFF;
    end else if (w_load) begin
      r_tx_sr <= r_thr_full ? r_thr : 8'hFF;
    end else if (w_shift && (r_bit_cnt != 3'd0)) begin
      r_tx_sr <= {r_tx_sr[6:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_thr      <= 8'h00;
      r_thr_full <= 1'b0;
    end else if (w_thr_wr) begin
      r_thr      <= tx_data;
      r_thr_full <= 1'b1;
    end else if (w_consume) begin
      r_thr_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sr    <= 8'hFF;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_sample) r_rx_sr <= {r_rx_sr[6:0], r_mosi_d};
      if (w_byte_done) begin
        r_rx_data  <= {r_rx_sr[6:0], r_mosi_d};
        r_rx_valid <= 1'b1;
      end else if (rx_read) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // Set events are OR-ed in after the clear so a simultaneous set survives.
  always_ff @(posedge clk) begin
    if (reset) r_status <= 3'b000;
    else       r_status <= (clear_status ? 3'b000 : r_status)
                         | {w_abort_set, w_overrun_set, w_underrun_set};
  end

  assign busy     = w_active;
  assign miso_oe  = w_active;
  assign miso_o   = w_active ? r_tx_sr[7] : 1'b1;
  assign tx_ready = ~r_thr_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign status   = r_status;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a bit-banged SPI master drives frames in all four modes
// and compares miso, received bytes and status against hand-computed values.
module tb_spi_slave_port;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck_i = 1'b0;
  logic       mosi_i = 1'b0;
  logic       ncs_i = 1'b1;
  logic       miso_o, miso_oe;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read = 1'b0;
  logic       busy;
  logic [2:0] status;
  logic       clear_status = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mi, mi2;

  spi_slave_port dut (
    .clk(clk), .reset(reset),
    .sck_i(sck_i), .mosi_i(mosi_i), .ncs_i(ncs_i),
    .miso_o(miso_o), .miso_oe(miso_oe),
    .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .busy(busy), .status(status), .clear_status(clear_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_thr(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 50) begin
      wait_clks(1);
      n++;
    end
    check("thr_ready_before_write", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
    wait_clks(1);
  endtask

  task automatic pulse_rx_read();
    rx_read = 1'b1;
    wait_clks(1);
    rx_read = 1'b0;
    wait_clks(1);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    wait_clks(1);
    clear_status = 1'b0;
    wait_clks(1);
  endtask

  task automatic start_frame(input logic c, input logic h);
    cpol  = c;
    cpha  = h;
    sck_i = c;
    wait_clks(HALF);
    ncs_i = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic end_frame();
    wait_clks(HALF);
    ncs_i = 1'b1;
    wait_clks(HALF);
  endtask

  // Master: sends mo MSB first for nbits bits, captures miso at its own sample edge.
  task automatic run_bits(input logic [7:0] mo, input int nbits, output logic [7:0] got);
    got = 8'hFF;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi_i = mo[i];
        wait_clks(HALF);
        got[i] = miso_o;
        sck_i = ~cpol;
        wait_clks(HALF);
        sck_i = cpol;
      end else begin
        sck_i = ~cpol;
        mosi_i = mo[i];
        wait_clks(HALF);
        got[i] = miso_o;
        sck_i = cpol;
        wait_clks(HALF);
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    wait_clks(4);
    reset = 1'b0;
    wait_clks(4);
    check("rst_busy",     busy,     0);
    check("rst_miso_oe",  miso_oe,  0);
    check("rst_miso",     miso_o,   1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data",  rx_data,  8'h00);
    check("rst_status",   status,   3'b000);

    // Mode 0, THR=A5, master sends 3C; THR refilled so the end-of-byte load does not underrun.
    write_thr(8'hA5);
    check("m0_thr_full", tx_ready, 0);
    start_frame(1'b0, 1'b0);
    check("m0_busy",     busy,     1);
    check("m0_miso_oe",  miso_oe,  1);
    check("m0_consumed", tx_ready, 1);
    check("m0_bit7",     miso_o,   1);
    write_thr(8'h5A);
    run_bits(8'h3C, 8, mi);
    check("m0_miso_byte", mi, 8'hA5);
    end_frame();
    check("m0_rx_data",  rx_data,  8'h3C);
    check("m0_rx_valid", rx_valid, 1);
    check("m0_status",   status,   3'b000);
    check("m0_idle",     busy,     0);
    check("m0_idle_oe",  miso_oe,  0);
    check("m0_idle_miso", miso_o,  1);
    pulse_rx_read();
    check("m0_rx_read", rx_valid, 0);

    // Mode 3, two-byte frame, THR refilled with 81 after the first consume.
    write_thr(8'hC3);
    start_frame(1'b1, 1'b1);
    write_thr(8'h81);
    run_bits(8'h12, 8, mi);
    check("m3_miso_b1",  mi,       8'hC3);
    check("m3_rx_v1",    rx_valid, 1);
    check("m3_rx_d1",    rx_data,  8'h12);
    pulse_rx_read();
    write_thr(8'hEE);
    run_bits(8'h34, 8, mi2);
    check("m3_miso_b2",  mi2,      8'h81);
    end_frame();
    check("m3_rx_v2",    rx_valid, 1);
    check("m3_rx_d2",    rx_data,  8'h34);
    check("m3_status",   status,   3'b000);
    pulse_rx_read();

    // Mode 1 with THR empty: idle-fill and underrun.
    start_frame(1'b0, 1'b1);
    check("m1_empty_ready", tx_ready, 1);
    run_bits(8'h00, 8, mi);
    end_frame();
    check("m1_miso_ff",  mi,       8'hFF);
    check("m1_status",   status,   3'b001);
    check("m1_rx_data",  rx_data,  8'h00);
    pulse_rx_read();
    pulse_clear();
    check("m1_cleared",  status,   3'b000);

    // Two bytes without rx_read: overrun.
    write_thr(8'h11);
    start_frame(1'b0, 1'b0);
    write_thr(8'h22);
    run_bits(8'h6A, 8, mi);
    write_thr(8'h33);
    run_bits(8'h95, 8, mi2);
    end_frame();
    check("ov_miso_b1",  mi,       8'h11);
    check("ov_miso_b2",  mi2,      8'h22);
    check("ov_rx_data",  rx_data,  8'h95);
    check("ov_rx_valid", rx_valid, 1);
    check("ov_status",   status,   3'b010);
    pulse_rx_read();
    check("ov_rx_read",  rx_valid, 0);
    pulse_clear();

    // Abort after 5 bits, then a clean frame; the retained THR byte 55 is sent.
    write_thr(8'h44);
    start_frame(1'b0, 1'b0);
    write_thr(8'h55);
    run_bits(8'hF0, 5, mi);
    end_frame();
    check("ab_status",   status,   3'b100);
    check("ab_rx_valid", rx_valid, 0);
    check("ab_rx_data",  rx_data,  8'h95);
    check("ab_thr_kept", tx_ready, 0);
    pulse_clear();
    start_frame(1'b0, 1'b0);
    write_thr(8'h66);
    run_bits(8'hC9, 8, mi);
    end_frame();
    check("ab_next_miso",  mi,       8'h55);
    check("ab_next_rx",    rx_data,  8'hC9);
    check("ab_next_valid", rx_valid, 1);
    check("ab_next_status", status,  3'b000);
    pulse_rx_read();

    // Reset pulsed after 3 bits, ncs still low.
    write_thr(8'h77);
    start_frame(1'b0, 1'b0);
    run_bits(8'hAB, 3, mi);
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(2);
    check("mr_busy",     busy,     0);
    check("mr_miso_oe",  miso_oe,  0);
    check("mr_miso",     miso_o,   1);
    check("mr_tx_ready", tx_ready, 1);
    check("mr_rx_valid", rx_valid, 0);
    check("mr_rx_data",  rx_data,  8'h00);
    check("mr_status",   status,   3'b000);
    wait_clks(HALF);
    check("mr_stay_idle", busy, 0);
    ncs_i = 1'b1;
    wait_clks(HALF);
    check("mr_idle_after_ncs", busy, 0);

    // Mode 2 after reset.
    write_thr(8'h9C);
    start_frame(1'b1, 1'b0);
    write_thr(8'h00);
    run_bits(8'h5E, 8, mi);
    end_frame();
    check("m2_miso_byte", mi,       8'h9C);
    check("m2_rx_data",   rx_data,  8'h5E);
    check("m2_rx_valid",  rx_valid, 1);
    check("m2_status",    status,   3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; clock clk.
REQ-003 sck_i, mosi_i, ncs_i  input  1 each  asynchronous SPI bus pins; ncs_i is active-low.
REQ-004 miso_o  output  1  serial data out; miso_oe  output  1  driver enable for miso_o.
REQ-005 cpol, cpha  input  1 each  SPI mode; sampled only while the block is IDLE.
REQ-006 tx_data  input  8  next byte to send; tx_valid  input  1; tx_ready  output  1  transmit holding register (THR) empty.
REQ-007 rx_data  output  8  last received byte; rx_valid  output  1  byte pending; rx_read  input  1  consumer acknowledge.
REQ-008 busy  output  1  frame active; status  output  3  {abort, overrun, underrun}, all sticky; clear_status  input  1  clears all three.

Function
REQ-009 sck_i, mosi_i and ncs_i each SHALL pass through a 2-flop synchronizer, plus one history flop for edge detection.
REQ-010 Bus timing: sck high and low phases SHALL each be >= 4 clk periods; ncs_i setup/hold to the first/last sck edge SHALL be >= 4 clk periods.
REQ-011 Leading edge = synchronized sck leaving the cpol level; trailing edge = sck returning to the cpol level.
REQ-012 Sample edge SHALL be the leading edge when cpha=0 and the trailing edge when cpha=1; the opposite edge is the shift (launch) edge.
REQ-013 Bit order SHALL be MSB first on both miso_o and mosi_i.
REQ-014 FSM states SHALL be IDLE and ACTIVE.
REQ-015 IDLE->ACTIVE transition SHALL occur on a synchronized ncs falling edge; cpol/cpha SHALL be latched into mode registers at this transition.
REQ-016 ACTIVE->IDLE transition SHALL occur on a synchronized ncs rising edge.
REQ-017 busy SHALL be 1 exactly while the FSM is in ACTIVE.
REQ-018 miso_oe SHALL equal busy.
REQ-019 miso_o SHALL drive the TX shift register MSB while ACTIVE, and 1 while IDLE.
REQ-020 Byte load: on entering ACTIVE, and on the clk after the 8th sample of each byte, the TX shift register SHALL load from the THR; the THR then becomes empty and tx_ready=1.
REQ-021 If the THR is empty at a byte load, the shift register SHALL load 8'hFF and status[0] (underrun) SHALL be set.
REQ-022 cpha=0: bit7 SHALL be on miso_o within 1 clk of the ACTIVE entry; the register shifts left on each trailing edge, except the trailing edge after the 8th sample, where the byte load occurs instead.
REQ-023 cpha=1: the register shifts on each leading edge except the first leading edge of a byte, which presents bit7 unchanged.
REQ-024 A THR write occurs when tx_valid && tx_ready.
REQ-025 tx_ready SHALL fall the cycle after a THR write and rise the cycle after the THR is consumed.
REQ-026 A write and a consume in the same cycle SHALL leave the THR full, holding the new byte, with no underrun.
REQ-027 RX: each sample edge shifts mosi into the RX shift register; a 3-bit counter counts samples.
REQ-028 On the 8th sample, rx_data SHALL update and rx_valid SHALL be set on the next clk; the counter wraps to 0.
REQ-029 rx_valid SHALL clear on rx_read.
REQ-030 If a new byte completes while rx_valid=1, rx_data SHALL be overwritten, rx_valid SHALL stay 1, and status[1] (overrun) SHALL be set.
REQ-031 Byte completion and rx_read in the same cycle SHALL leave rx_valid=1 with no overrun.
REQ-032 ncs rising edge with the counter != 0 SHALL discard partial RX bits, leave rx_data/rx_valid unchanged, and set status[2] (abort); the partially sent TX byte is lost and the THR is retained.
REQ-033 clear_status SHALL clear all status bits; a set event in the same cycle SHALL win.
REQ-034 sck edges while IDLE SHALL be ignored.
REQ-035 Any ncs falling edge SHALL restart the bit counter at 0.

Reset
REQ-036 reset SHALL force state=IDLE, shift registers=8'hFF, counter=0, THR empty, tx_ready=1, rx_data=0, rx_valid=0, status=0, miso_o=1, miso_oe=0, busy=0, and mode registers=0.
REQ-037 reset asserted mid-frame SHALL abort the frame without setting abort.
REQ-038 After reset is released with ncs_i already low, the block SHALL stay IDLE until the next ncs falling edge.

Verification
REQ-039 Mode 0, THR=8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid=1; status=0.
REQ-040 Mode 3, two-byte frame, THR refilled with 8'h81 after the first consume -> second miso byte 8'h81; two rx_valid events; no underrun.
REQ-041 Mode 1, THR empty at frame start -> miso=8'hFF; status=3'b001.
REQ-042 Two bytes received without rx_read -> rx_data=second byte; rx_valid=1; status=3'b010; then rx_read -> rx_valid=0.
REQ-043 ncs raised after 5 sck cycles -> status=3'b100; rx_valid unchanged; the next frame receives a full byte correctly starting from bit7.
REQ-044 reset pulsed after 3 bits of a frame -> all outputs at reset values; status=0; no rx_valid.
